// File: rtl/axis_stereo_fir.sv
// Stereo FIR between I2S receive and transmit AXIS streams. One time-shared MAC
// runs the left channel, then the right channel, once per accepted L/R packet.

module axis_stereo_fir_dline #(
    parameter int NTAPS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [23:0]   din,
    input  logic [AW-1:0] sel,
    output logic [23:0]   tap
);
    logic [NTAPS-1:0][23:0] line;

    // index 0 holds the newest sample; the oldest falls off the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            line <= '0;
        else if (push)
            line <= {line[NTAPS-2:0], din};
    end

    assign tap = line[sel];
endmodule

module axis_stereo_fir #(
    parameter int NTAPS     = 16,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 16
) (
    input  logic                       axis_clk,
    input  logic                       axis_resetn,
    input  logic [31:0]                s_axis_data,
    input  logic                       s_axis_valid,
    output logic                       s_axis_ready,
    input  logic                       s_axis_last,
    output logic [31:0]                m_axis_data,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic                       m_axis_last,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic                       frame_err
);
    localparam int AW    = $clog2(NTAPS);
    localparam int KW    = $clog2(NTAPS + 1);
    localparam int PW    = 24 + COEF_W;
    localparam int ACC_W = PW + AW;

    localparam logic [2:0] IN_L  = 3'd0;
    localparam logic [2:0] IN_R  = 3'd1;
    localparam logic [2:0] MAC_L = 3'd2;
    localparam logic [2:0] MAC_R = 3'd3;
    localparam logic [2:0] OUT_L = 3'd4;
    localparam logic [2:0] OUT_R = 3'd5;

    localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);
    localparam logic [ACC_W:0]    RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (COEF_FRAC - 1);

    logic [2:0]                   state;
    logic                         armed;
    logic [KW-1:0]                k;
    logic [AW-1:0]                k_idx;
    logic [23:0]                  l_hold;
    logic [23:0]                  res_l;
    logic [23:0]                  res_r;
    logic signed [ACC_W-1:0]      acc;
    logic [NTAPS-1:0][COEF_W-1:0] shadow;
    logic [NTAPS-1:0][COEF_W-1:0] active;

    logic                         s_hs;
    logic                         push;
    logic                         wr_hit;
    logic [1:0][23:0]             dl_din;
    logic [1:0][23:0]             dl_tap;
    logic [23:0]                  x;
    logic [COEF_W-1:0]            c;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W:0]        rnd;
    logic signed [ACC_W:0]        shifted;
    logic [ACC_W-23:0]            hi;
    logic [23:0]                  sat;
    logic                         unused_hi;

    assign unused_hi = ^s_axis_data[31:24];

    assign s_hs   = s_axis_valid && s_axis_ready;
    assign push   = (state == IN_R) && s_hs && s_axis_last;
    assign wr_hit = coef_we && (32'(coef_addr) < 32'(NTAPS));
    assign k_idx  = k[AW-1:0];

    assign dl_din[0] = l_hold;
    assign dl_din[1] = s_axis_data[23:0];

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            axis_stereo_fir_dline #(
                .NTAPS (NTAPS),
                .AW    (AW)
            ) u_dline (
                .clk   (axis_clk),
                .rst_n (axis_resetn),
                .push  (push),
                .din   (dl_din[ch]),
                .sel   (k_idx),
                .tap   (dl_tap[ch])
            );
        end
    endgenerate

    // Coefficient banks: the active bank is refreshed only when a packet enters
    // the MAC, and a write landing on that same cycle is forwarded into it.
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            shadow    <= '0;
            shadow[0] <= COEF_ONE;
            active    <= '0;
            active[0] <= COEF_ONE;
        end else begin
            if (wr_hit)
                shadow[coef_addr] <= coef_data;
            if (push) begin
                for (int i = 0; i < NTAPS; i++)
                    active[i] <= (wr_hit && 32'(coef_addr) == i) ? coef_data : shadow[i];
            end
        end
    end

    assign x        = (state == MAC_R) ? dl_tap[1] : dl_tap[0];
    assign c        = active[k_idx];
    assign prod     = PW'($signed(x)) * PW'($signed(c));
    assign prod_ext = {{AW{prod[PW-1]}}, prod};

    // round half up, then clamp to the 24-bit sample range
    assign rnd     = {acc[ACC_W-1], acc} + $signed(RND_HALF);
    assign shifted = rnd >>> COEF_FRAC;
    assign hi      = shifted[ACC_W:23];

    always_comb begin
        sat = shifted[23:0];
        if (!((&hi) || !(|hi)))
            sat = shifted[ACC_W] ? 24'h800000 : 24'h7FFFFF;
    end

    // Each MAC state spends NTAPS cycles accumulating plus one cycle to round
    // and store, giving 2*NTAPS+2 edges from right-word accept to output valid.
    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state     <= IN_L;
            armed     <= 1'b0;
            k         <= '0;
            acc       <= '0;
            l_hold    <= '0;
            res_l     <= '0;
            res_r     <= '0;
            frame_err <= 1'b0;
        end else begin
            armed     <= 1'b1;
            frame_err <= 1'b0;
            case (state)
                IN_L: begin
                    if (s_hs) begin
                        if (s_axis_last) begin
                            frame_err <= 1'b1;
                        end else begin
                            l_hold <= s_axis_data[23:0];
                            state  <= IN_R;
                        end
                    end
                end
                IN_R: begin
                    if (s_hs) begin
                        if (s_axis_last) begin
                            k     <= '0;
                            acc   <= '0;
                            state <= MAC_L;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IN_L;
                        end
                    end
                end
                MAC_L, MAC_R: begin
                    if (k == KW'(NTAPS)) begin
                        k   <= '0;
                        acc <= '0;
                        if (state == MAC_L) begin
                            res_l <= sat;
                            state <= MAC_R;
                        end else begin
                            res_r <= sat;
                            state <= OUT_L;
                        end
                    end else begin
                        acc <= acc + prod_ext;
                        k   <= k + 1'b1;
                    end
                end
                OUT_L: begin
                    if (m_axis_ready)
                        state <= OUT_R;
                end
                OUT_R: begin
                    if (m_axis_ready)
                        state <= IN_L;
                end
                default: state <= IN_L;
            endcase
        end
    end

    // Outputs decode straight from the state so a reset clears them at once.
    assign s_axis_ready = armed && ((state == IN_L) || (state == IN_R));
    assign m_axis_valid = (state == OUT_L) || (state == OUT_R);
    assign m_axis_last  = (state == OUT_R);

    always_comb begin
        m_axis_data = 32'd0;
        if (state == OUT_L)
            m_axis_data = {{8{res_l[23]}}, res_l};
        else if (state == OUT_R)
            m_axis_data = {{8{res_r[23]}}, res_r};
    end
endmodule

// File: tb/tb_axis_stereo_fir.sv
// Bench for axis_stereo_fir: directed cases pinned to literal results plus a
// randomized run, all checked every cycle against a sample-history FIR model.

module tb_axis_stereo_fir;
    localparam int NTAPS  = 16;
    localparam int COEF_W = 18;
    localparam int CF     = 16;
    localparam int AW     = $clog2(NTAPS);

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [31:0]       s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready = 1'b1;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              frame_err;

    int checks = 0;
    int errors = 0;

    // model state
    int          hl[NTAPS];
    int          hr[NTAPS];
    int          sh[NTAPS];
    int          l_pend;
    bit          phase;
    bit          busy;
    bit          ferr_pend;
    int          cyc = 0;
    int          deadline = 0;
    int          armed_cnt;
    int          ferr_cnt = 0;
    exp_t        exp_q[$];
    logic [31:0] out_log[$];
    bit          rnd_mready = 1'b0;
    bit          mready_fix = 1'b1;

    always #5 clk = ~clk;

    axis_stereo_fir #(.NTAPS(NTAPS), .COEF_W(COEF_W), .COEF_FRAC(CF)) dut (
        .axis_clk     (clk),
        .axis_resetn  (rstn),
        .s_axis_data  (s_data),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_last  (s_last),
        .m_axis_data  (m_data),
        .m_axis_valid (m_valid),
        .m_axis_ready (m_ready),
        .m_axis_last  (m_last),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .frame_err    (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fir(input int h[NTAPS], input int cf[NTAPS]);
        longint s = 0;
        for (int i = 0; i < NTAPS; i++)
            s += longint'(h[i]) * longint'(cf[i]);
        s = (s + (longint'(1) << (CF - 1))) >>> CF;
        if (s > 64'sd8388607)  s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return 32'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn)
            armed_cnt <= 0;
        else if (armed_cnt < 2)
            armed_cnt <= armed_cnt + 1;
    end

    always begin
        @(posedge clk);
        #1;
        m_ready = rnd_mready ? ($urandom_range(0, 3) != 0) : mready_fix;
    end

    // Compare process and model update, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_last", 32'(m_last), 32'd0);
            chk("rst_m_data", m_data, 32'd0);
            chk("rst_s_ready", 32'(s_ready), 32'd0);
            chk("rst_frame_err", 32'(frame_err), 32'd0);
            for (int i = 0; i < NTAPS; i++) begin
                hl[i] = 0;
                hr[i] = 0;
                sh[i] = 0;
            end
            sh[0] = 1 << CF;
            phase = 1'b0;
            busy = 1'b0;
            ferr_pend = 1'b0;
            l_pend = 0;
            exp_q.delete();
        end else begin
            if (armed_cnt > 0)
                chk("s_ready", 32'(s_ready), 32'(!busy));
            chk("frame_err", 32'(frame_err), 32'(ferr_pend));
            if (frame_err) ferr_cnt++;
            chk("m_valid", 32'(m_valid), 32'(busy && cyc >= deadline));
            if (m_valid && exp_q.size() > 0) begin
                chk("m_data", m_data, exp_q[0].data);
                chk("m_last", 32'(m_last), 32'(exp_q[0].last));
            end
            ferr_pend = 1'b0;
            if (coef_we)
                sh[coef_addr] = int'($signed(coef_data));
            if (s_valid && s_ready) begin
                if (!phase) begin
                    if (s_last) ferr_pend = 1'b1;
                    else begin
                        l_pend = int'($signed(s_data[23:0]));
                        phase = 1'b1;
                    end
                end else begin
                    phase = 1'b0;
                    if (!s_last) ferr_pend = 1'b1;
                    else begin
                        for (int i = NTAPS - 1; i > 0; i--) begin
                            hl[i] = hl[i-1];
                            hr[i] = hr[i-1];
                        end
                        hl[0] = l_pend;
                        hr[0] = int'($signed(s_data[23:0]));
                        exp_q.push_back('{fir(hl, sh), 1'b0});
                        exp_q.push_back('{fir(hr, sh), 1'b1});
                        busy = 1'b1;
                        deadline = cyc + 2 * NTAPS + 3;
                    end
                end
            end
            if (m_valid && m_ready && exp_q.size() > 0) begin
                out_log.push_back(m_data);
                if (exp_q[0].last) busy = 1'b0;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last = 1'b0;
        coef_we = 1'b0;
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic we = 1'b0,
                             input logic [AW-1:0] a = '0, input logic [COEF_W-1:0] cd = '0);
        bit ok = 1'b0;
        s_data = d;
        s_last = last;
        s_valid = 1'b1;
        coef_we = we;
        coef_addr = a;
        coef_data = cd;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        coef_we = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_pkt(input logic [31:0] l, input logic [31:0] r);
        send_word(l, 1'b0);
        send_word(r, 1'b1);
    endtask

    task automatic write_coef(input int a, input logic [COEF_W-1:0] cd);
        coef_we = 1'b1;
        coef_addr = AW'(a);
        coef_data = cd;
        tick(1);
        coef_we = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("idle_reached", 32'(ok), 32'd1);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("valid_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n;
        logic [31:0] d;
        logic [31:0] e;
        logic [COEF_W-1:0] cd;

        // 1: identity pass-through and latency
        do_reset();
        out_log.delete();
        send_pkt(32'h00000123, 32'h00FFFFFE);
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            n++;
            if (m_valid) break;
        end
        chk("latency", 32'(n - 1), 32'd34);
        wait_idle();
        chk("t1_left", out_log[0], 32'h00000123);
        chk("t1_right", out_log[1], 32'hFFFFFFFE);

        // 2: 4-tap 0.25 box on an impulse
        do_reset();
        for (int i = 0; i < NTAPS; i++) write_coef(i, (i < 4) ? 18'h04000 : 18'h0);
        out_log.delete();
        for (int p = 0; p < 5; p++) begin
            send_pkt((p == 0) ? 32'h00400000 : 32'h0, 32'h0);
            wait_idle();
        end
        for (int p = 0; p < 5; p++) begin
            e = (p < 4) ? 32'h00100000 : 32'h0;
            chk("t2_left", out_log[2*p], e);
            chk("t2_right", out_log[2*p+1], 32'h0);
        end

        // 3: saturation
        do_reset();
        for (int i = 0; i < NTAPS; i++) write_coef(i, 18'h10000);
        out_log.delete();
        for (int p = 0; p < 5; p++) begin
            send_pkt(32'h007FFFFF, 32'h00800000);
            wait_idle();
        end
        for (int p = 0; p < 5; p++) begin
            chk("t3_left", out_log[2*p], 32'h007FFFFF);
            chk("t3_right", out_log[2*p+1], 32'hFF800000);
        end

        // 4: framing errors leave the delay lines alone
        do_reset();
        write_coef(1, 18'h10000);
        out_log.delete();
        ferr_cnt = 0;
        send_word(32'h00000999, 1'b1);
        tick(5);
        chk("t4_no_output", 32'(out_log.size()), 32'd0);
        chk("t4_ferr1", 32'(ferr_cnt), 32'd1);
        send_word(32'h00000111, 1'b0);
        send_word(32'h00000222, 1'b0);
        tick(3);
        chk("t4_ferr2", 32'(ferr_cnt), 32'd2);
        send_pkt(32'h00000333, 32'h00000444);
        wait_idle();
        send_pkt(32'h00000010, 32'h00000020);
        wait_idle();
        chk("t4_l0", out_log[0], 32'h00000333);
        chk("t4_r0", out_log[1], 32'h00000444);
        chk("t4_l1", out_log[2], 32'h00000343);
        chk("t4_r1", out_log[3], 32'h00000464);

        // 5: backpressure during OUT_L with a new packet waiting upstream
        out_log.delete();
        mready_fix = 1'b0;
        send_pkt(32'h000ABCDE, 32'h007FFF00);
        wait_valid();
        s_data = 32'h00000005;
        s_last = 1'b0;
        s_valid = 1'b1;
        tick(100);
        chk("t5_held_data", m_data, 32'h000ABCEE);
        chk("t5_held_last", 32'(m_last), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        mready_fix = 1'b1;
        send_word(32'h00000005, 1'b0);
        send_word(32'h00000006, 1'b1);
        wait_idle();
        chk("t5_l", out_log[0], 32'h000ABCEE);
        chk("t5_r", out_log[1], 32'h007FFF20);

        // 6: coefficient timing, same-cycle bypass, reset mid-operation
        do_reset();
        out_log.delete();
        send_pkt(32'h00001000, 32'h00002000);
        tick(NTAPS + 4);
        write_coef(0, 18'h0);
        wait_idle();
        send_pkt(32'h00000055, 32'h00000066);
        wait_idle();
        send_word(32'h00000040, 1'b0);
        send_word(32'h00000080, 1'b1, 1'b1, '0, 18'h08000);
        wait_idle();
        chk("t6_cur_l", out_log[0], 32'h00001000);
        chk("t6_cur_r", out_log[1], 32'h00002000);
        chk("t6_next_l", out_log[2], 32'h0);
        chk("t6_next_r", out_log[3], 32'h0);
        chk("t6_byp_l", out_log[4], 32'h00000020);
        chk("t6_byp_r", out_log[5], 32'h00000040);

        send_pkt(32'h00000123, 32'h00000456);
        tick(5);
        rstn = 1'b0;
        #1;
        chk("t6_mac_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_mac_rst_ready", 32'(s_ready), 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);
        mready_fix = 1'b0;
        send_pkt(32'h00000321, 32'h00000654);
        wait_valid();
        rstn = 1'b0;
        #1;
        chk("t6_out_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_out_rst_data", m_data, 32'h0);
        chk("t6_out_rst_ready", 32'(s_ready), 32'd0);
        tick(2);
        rstn = 1'b1;
        mready_fix = 1'b1;
        tick(2);
        out_log.delete();
        write_coef(1, 18'h10000);
        send_pkt(32'h00000077, 32'h00000088);
        wait_idle();
        chk("t6_post_rst_l", out_log[0], 32'h00000077);
        chk("t6_post_rst_r", out_log[1], 32'h00000088);

        // randomized traffic, coefficient updates, framing faults, backpressure
        rnd_mready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int r;
            r = $urandom_range(0, 9);
            d = $urandom();
            if (d[31]) d[23:0] = 24'($urandom_range(0, 511)) - 24'd256;
            cd = COEF_W'($urandom_range(0, 65535)) - COEF_W'(32768);
            if (r == 0) begin
                send_word(d, 1'b1);
            end else if (r == 1) begin
                send_word(d, 1'b0);
                send_word($urandom(), 1'b0);
            end else begin
                if (r < 5) write_coef($urandom_range(0, NTAPS - 1), cd);
                send_word(d, 1'b0);
                if (r == 5)
                    send_word($urandom(), 1'b1, 1'b1, AW'($urandom_range(0, NTAPS - 1)), cd);
                else
                    send_word($urandom(), 1'b1);
            end
            tick($urandom_range(0, 2));
        end
        wait_idle();
        rnd_mready = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
